// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard, stall and flush controller for the 5-stage core.
//               Produces operand-forwarding selects for the Execute stage,
//               load-use and PC-write hazard stalls/flushes, a ready/wait
//               handshake with data memory that aborts after TIMEOUT
//               consecutive wait cycles, and saturating stall/flush
//               event counters.
// Ports       :
//   clk, rst                  clock, synchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E      source register addresses in Decode/Execute
//   WA3E/WA3M/WA3W            destination addresses in Execute/Memory/Writeback
//   RegWriteM/W, MemtoRegE    register-write and load control bits
//   MemWriteM, MemtoRegM      memory access in the Memory stage
//   PCSrcD/E/M/W              PC-writing instruction in each stage
//   BranchTakenE              branch resolved taken in Execute
//   mem_ready                 data memory completes its access this cycle
//   clr_cnt                   synchronous clear of the event counters
//   ForwardAE/BE              00 regfile, 10 ALUResultM, 01 ResultW
//   StallF/D/E/M              hold pipeline registers
//   FlushD/E/W                insert bubble into D/E/W registers
//   mem_err                   one-cycle pulse while the aborted access drains
//   stall_cnt, flush_cnt      saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W   = 4,
    parameter int PC_ADDR = 15,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] WA3E,
    input  logic [REG_W-1:0] WA3M,
    input  logic [REG_W-1:0] WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               c_WAIT_W    = $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [REG_W-1:0] c_PC        = REG_W'(PC_ADDR);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [0:0] c_S_WAIT_OK = 1'b0;
    localparam logic [0:0] c_S_ABORT   = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_nextState;
    logic [0:0]          w_stateEff;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [c_WAIT_W-1:0] w_nextWait;
    logic                r_memErr;
    logic                w_timeout;
    logic                w_ldrStall;
    logic                w_pcPend;
    logic                w_memStall;
    logic [CNT_W-1:0]    r_stallCnt;
    logic [CNT_W-1:0]    r_flushCnt;

    // While reset is asserted the combinational outputs behave as if the
    // FSM were already in WAIT_OK, independent of the stale register value.
    assign w_stateEff = rst ? r_state : c_S_WAIT_OK;

    // Forwarding: Memory stage wins over Writeback; the PC is never forwarded.
    assign ForwardAE = (RegWriteM && (WA3M == RA1E) && (RA1E != c_PC)) ? 2'b10 :
                       (RegWriteW && (WA3W == RA1E) && (RA1E != c_PC)) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && (WA3M == RA2E) && (RA2E != c_PC)) ? 2'b10 :
                       (RegWriteW && (WA3W == RA2E) && (RA2E != c_PC)) ? 2'b01 : 2'b00;

    assign w_ldrStall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign w_pcPend   = PCSrcD | PCSrcE | PCSrcM;
    assign w_memStall = (MemWriteM | MemtoRegM) && !mem_ready && (w_stateEff == c_S_WAIT_OK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_S_WAIT_OK;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
            r_memErr  <= w_timeout;
        end
    end

    always_comb begin
        w_nextState = w_stateEff;
        w_nextWait  = '0;
        w_timeout   = 1'b0;
        StallF      = w_ldrStall | w_pcPend;
        StallD      = w_ldrStall;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushE      = w_ldrStall | BranchTakenE;
        FlushD      = w_pcPend | PCSrcW | BranchTakenE;
        FlushW      = (w_stateEff == c_S_ABORT);

        case (w_stateEff)
            c_S_WAIT_OK: begin
                if (w_memStall) begin
                    if (r_waitCnt == c_WAIT_LAST) begin
                        w_timeout   = 1'b1;
                        w_nextState = c_S_ABORT;
                    end else begin
                        w_nextWait = r_waitCnt + c_WAIT_W'(1);
                    end
                end
            end
            c_S_ABORT: begin
                // Single drain cycle: FlushW drops the timed-out access.
                w_nextState = c_S_WAIT_OK;
            end
            default: begin
                w_nextState = c_S_WAIT_OK;
            end
        endcase

        // A memory wait freezes the whole pipe; any branch flush is held off
        // and naturally re-asserts once E is released because E was frozen.
        if (w_memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_cnt) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (StallF && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if ((FlushD || FlushE) && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign mem_err   = r_memErr;
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=2).
//               Directed vector table, hand-written multi-cycle sequences and
//               randomized stimulus compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       regWriteM, regWriteW, memtoRegE, memWriteM, memtoRegM;
        logic       pcSrcD, pcSrcE, pcSrcM, pcSrcW, branchTakenE;
        logic       memReady, clrCnt;
    } vin_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sF, sD, sE, sM, fD, fE, fW;
    } exp_t;

    typedef struct {
        vin_t       v;
        logic [1:0] fa, fb;
        logic       sF, sD, fD, fE;
    } vec_t;

    logic          clk = 1'b0;
    vin_t          cur;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    int nStallM = 0;
    int nErr = 0;

    // Behavioural model state
    int mWait = 0;
    bit mAbort = 0;
    bit mErr = 0;
    int mStall = 0;
    int mFlush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(4), .PC_ADDR(15), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(cur.rst),
        .RA1D(cur.ra1d), .RA2D(cur.ra2d), .RA1E(cur.ra1e), .RA2E(cur.ra2e),
        .WA3E(cur.wa3e), .WA3M(cur.wa3m), .WA3W(cur.wa3w),
        .RegWriteM(cur.regWriteM), .RegWriteW(cur.regWriteW), .MemtoRegE(cur.memtoRegE),
        .MemWriteM(cur.memWriteM), .MemtoRegM(cur.memtoRegM),
        .PCSrcD(cur.pcSrcD), .PCSrcE(cur.pcSrcE), .PCSrcM(cur.pcSrcM), .PCSrcW(cur.pcSrcW),
        .BranchTakenE(cur.branchTakenE), .mem_ready(cur.memReady), .clr_cnt(cur.clrCnt),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vin_t base();
        vin_t v;
        v = '0;
        v.rst = 1'b1; v.memReady = 1'b1;
        v.ra1d = 4'd1; v.ra2d = 4'd2; v.ra1e = 4'd6; v.ra2e = 4'd7;
        v.wa3e = 4'd8; v.wa3m = 4'd9; v.wa3w = 4'd10;
        return v;
    endfunction

    function automatic logic [1:0] fwdSel(input logic [3:0] ra, input vin_t v);
        if (ra == 4'd15) return 2'd0;
        if (v.regWriteM && v.wa3m == ra) return 2'b10;
        if (v.regWriteW && v.wa3w == ra) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t modelComb(input vin_t v);
        exp_t e;
        bit aborting, ldr, pend, memStall;
        aborting = v.rst ? mAbort : 1'b0;
        ldr      = v.memtoRegE && (v.wa3e == v.ra1d || v.wa3e == v.ra2d);
        pend     = v.pcSrcD || v.pcSrcE || v.pcSrcM;
        memStall = (v.memWriteM || v.memtoRegM) && !v.memReady && !aborting;
        e.fa = fwdSel(v.ra1e, v);
        e.fb = fwdSel(v.ra2e, v);
        if (memStall) begin
            e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fD = 0; e.fE = 0; e.fW = 1;
        end else begin
            e.sF = ldr || pend; e.sD = ldr; e.sE = 0; e.sM = 0;
            e.fE = ldr || v.branchTakenE;
            e.fD = pend || v.pcSrcW || v.branchTakenE;
            e.fW = aborting;
        end
        return e;
    endfunction

    task automatic modelEdge(input vin_t v, input exp_t e);
        if (!v.rst) begin
            mWait = 0; mAbort = 0; mErr = 0; mStall = 0; mFlush = 0;
        end else begin
            // e.sM is high exactly when the memory wait is active
            mErr   = e.sM && (mWait == TO - 1);
            mAbort = mErr;
            mWait  = (e.sM && !mErr) ? mWait + 1 : 0;
            if (v.clrCnt) begin
                mStall = 0; mFlush = 0;
            end else begin
                if (e.sF && mStall < SAT) mStall++;
                if ((e.fD || e.fE) && mFlush < SAT) mFlush++;
            end
        end
    endtask

    task automatic step(input vin_t v);
        exp_t e;
        cur = v;
        #2;
        e = modelComb(v);
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
        chk("StallF", 32'(StallF), 32'(e.sF));
        chk("StallD", 32'(StallD), 32'(e.sD));
        chk("StallE", 32'(StallE), 32'(e.sE));
        chk("StallM", 32'(StallM), 32'(e.sM));
        chk("FlushD", 32'(FlushD), 32'(e.fD));
        chk("FlushE", 32'(FlushE), 32'(e.fE));
        chk("FlushW", 32'(FlushW), 32'(e.fW));
        if (StallM === 1'b1) nStallM++;
        @(posedge clk);
        modelEdge(v, e);
        #1;
        chk("mem_err", 32'(mem_err), 32'(mErr));
        chk("stall_cnt", 32'(stall_cnt), 32'(mStall));
        chk("flush_cnt", 32'(flush_cnt), 32'(mFlush));
        if (mem_err === 1'b1) nErr++;
    endtask

    function automatic logic [3:0] rndReg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    vec_t tbl[8];

    initial begin
        vin_t v;

        // Directed vector table (Memory stage idle, FSM in WAIT_OK)
        v = base(); v.regWriteM = 1; v.wa3m = 3; v.ra1e = 3; v.regWriteW = 1; v.wa3w = 3;
        tbl[0] = '{v, 2'b10, 2'b00, 0, 0, 0, 0};
        v = base(); v.regWriteM = 1; v.regWriteW = 1; v.ra1e = 15; v.wa3m = 15; v.wa3w = 15;
        tbl[1] = '{v, 2'b00, 2'b00, 0, 0, 0, 0};
        v = base(); v.regWriteW = 1; v.wa3w = 7;
        tbl[2] = '{v, 2'b00, 2'b01, 0, 0, 0, 0};
        v = base(); v.memtoRegE = 1; v.wa3e = 5; v.ra2d = 5;
        tbl[3] = '{v, 2'b00, 2'b00, 1, 1, 0, 1};
        v = base(); v.pcSrcE = 1;
        tbl[4] = '{v, 2'b00, 2'b00, 1, 0, 1, 0};
        v = base(); v.pcSrcE = 1; v.branchTakenE = 1;
        tbl[5] = '{v, 2'b00, 2'b00, 1, 0, 1, 1};
        v = base(); v.pcSrcW = 1;
        tbl[6] = '{v, 2'b00, 2'b00, 0, 0, 1, 0};
        v = base(); v.regWriteM = 1; v.wa3m = 7; v.regWriteW = 1; v.wa3w = 7;
        tbl[7] = '{v, 2'b00, 2'b10, 0, 0, 0, 0};

        // Reset
        v = base(); v.rst = 0;
        cur = v;
        @(posedge clk); #1;
        step(v);
        step(v);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            cur = tbl[i].v;
            #2;
            chk($sformatf("tbl%0d_FwdA", i), 32'(ForwardAE), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d_FwdB", i), 32'(ForwardBE), 32'(tbl[i].fb));
            chk($sformatf("tbl%0d_StallF", i), 32'(StallF), 32'(tbl[i].sF));
            chk($sformatf("tbl%0d_StallD", i), 32'(StallD), 32'(tbl[i].sD));
            chk($sformatf("tbl%0d_FlushD", i), 32'(FlushD), 32'(tbl[i].fD));
            chk($sformatf("tbl%0d_FlushE", i), 32'(FlushE), 32'(tbl[i].fE));
            step(tbl[i].v);
        end

        // Load-use: +1 per cycle, then saturation at 3, then clear
        v = base(); v.clrCnt = 1; step(v);
        v = base(); v.memtoRegE = 1; v.wa3e = 5; v.ra2d = 5;
        step(v);
        chk("ldr_stall_cnt_first", 32'(stall_cnt), 32'd1);
        chk("ldr_flush_cnt_first", 32'(flush_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step(v);
        chk("stall_cnt_sat", 32'(stall_cnt), 32'd3);
        chk("flush_cnt_sat", 32'(flush_cnt), 32'd3);
        v.clrCnt = 1; step(v);
        chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
        chk("flush_cnt_clr", 32'(flush_cnt), 32'd0);

        // Load waits 3 cycles; ready arrives on the last allowed wait cycle
        step(base());
        nStallM = 0; nErr = 0;
        v = base(); v.memtoRegM = 1; v.memReady = 0;
        for (int i = 0; i < 3; i++) step(v);
        v.memReady = 1; step(v);
        chk("wait3_stall_cycles", 32'(nStallM), 32'd3);
        chk("wait3_no_err", 32'(nErr), 32'd0);

        // Store times out: 4 stalled cycles then one abort cycle
        step(base());
        nStallM = 0; nErr = 0;
        v = base(); v.memWriteM = 1; v.memReady = 0;
        for (int i = 0; i < 5; i++) step(v);
        chk("timeout_stall_cycles", 32'(nStallM), 32'd4);
        chk("timeout_err_pulses", 32'(nErr), 32'd1);
        step(base());

        // Branch during memory stall: flush held off, applied after release
        v = base(); v.memtoRegM = 1; v.memReady = 0; v.branchTakenE = 1;
        step(v); step(v);
        v.memReady = 1; step(v);
        step(base());

        // Reset mid-wait discards the accumulated wait count
        v = base(); v.memWriteM = 1; v.memReady = 0;
        step(v); step(v);
        v.rst = 0; step(v);
        v.rst = 1;
        nStallM = 0; nErr = 0;
        for (int i = 0; i < 5; i++) step(v);
        chk("rst_wait_stall_cycles", 32'(nStallM), 32'd4);
        chk("rst_wait_err_pulses", 32'(nErr), 32'd1);
        step(base());

        // Randomized against the model
        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 39) != 0);
            v.ra1d = rndReg(); v.ra2d = rndReg(); v.ra1e = rndReg(); v.ra2e = rndReg();
            v.wa3e = rndReg(); v.wa3m = rndReg(); v.wa3w = rndReg();
            v.regWriteM = 1'($urandom_range(0, 1));
            v.regWriteW = 1'($urandom_range(0, 1));
            v.memtoRegE = 1'($urandom_range(0, 1));
            v.memWriteM = 1'($urandom_range(0, 1));
            v.memtoRegM = 1'($urandom_range(0, 1));
            v.pcSrcD = ($urandom_range(0, 5) == 0);
            v.pcSrcE = ($urandom_range(0, 5) == 0);
            v.pcSrcM = ($urandom_range(0, 5) == 0);
            v.pcSrcW = ($urandom_range(0, 5) == 0);
            v.branchTakenE = ($urandom_range(0, 4) == 0);
            v.memReady = ($urandom_range(0, 9) < ((i % 60) < 30 ? 7 : 1));
            v.clrCnt = ($urandom_range(0, 11) == 0);
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
